// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data cache memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LINE_BITS  = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_I    = 2'b01,
        GRANT_D    = 2'b10
    } grant_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    // Identifies which port completed the most recent transaction.
    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } last_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational picker: turns the two request levels plus the last-served port into a one-hot grant.
module arb_grant_sel
    import mem_arb_pkg::*;
(
    input  logic  i_req,
    input  logic  d_req,
    input  last_t last_served,
    output grant_t grant
);

    // On a tie the port that was not served last wins.
    always_comb begin
        grant = GRANT_NONE;
        case ({d_req, i_req})
            2'b01:   grant = GRANT_I;
            2'b10:   grant = GRANT_D;
            2'b11:   grant = (last_served == LAST_D) ? GRANT_I : GRANT_D;
            default: grant = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) line arbiter in front of a single memory port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate ties; otherwise dcache wins ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_BITS  = DEF_LINE_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_BITS-1:0]  i_rdata,
    output logic                  i_ready,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_BITS-1:0]  d_wdata,
    output logic [LINE_BITS-1:0]  d_rdata,
    output logic                  d_ready,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_BITS-1:0]  mem_wdata,
    input  logic [LINE_BITS-1:0]  mem_rdata,
    input  logic                  mem_ready,
    output logic [1:0]            grant
);

    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);

    arb_state_t            state_r;
    arb_state_t            state_nxt_s;
    grant_t                sel_grant_s;
    grant_t                grant_r;
    last_t                 last_sel_s;
    mem_op_t               op_s;
    logic                  d_req_s;
    logic                  load_s;
    logic                  done_s;
    logic [ADDR_WIDTH-1:0] req_addr_s;
    logic [ADDR_WIDTH-1:0] aligned_addr_s;
    logic                  mem_read_r;
    logic                  mem_write_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [LINE_BITS-1:0]  mem_wdata_r;

    assign d_req_s = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_t last_r;

    // Remember which port finished last so ties go to the other one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r <= LAST_I;
        end else if (done_s) begin
            last_r <= (state_r == ST_SERVE_D) ? LAST_D : LAST_I;
        end else begin
            last_r <= last_r;
        end
    end

    assign last_sel_s = last_r;
`else
    // Pretending icache went last makes every tie fall to dcache.
    assign last_sel_s = LAST_I;
`endif

    arb_grant_sel u_grant_sel (
        .i_req       (i_read),
        .d_req       (d_req_s),
        .last_served (last_sel_s),
        .grant       (sel_grant_s)
    );

    // Pick the winner's address and operation; a write-back beats a fill on the dcache port.
    always_comb begin
        req_addr_s = i_addr;
        op_s       = OP_READ;
        if (sel_grant_s == GRANT_D) begin
            req_addr_s = d_addr;
            op_s       = d_write ? OP_WRITE : OP_READ;
        end else begin
            req_addr_s = i_addr;
            op_s       = OP_READ;
        end
    end

    assign aligned_addr_s = {req_addr_s[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic with load/complete strobes for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sel_grant_s == GRANT_I) begin
                    state_nxt_s = ST_SERVE_I;
                    load_s      = 1'b1;
                end else if (sel_grant_s == GRANT_D) begin
                    state_nxt_s = ST_SERVE_D;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (mem_ready) begin
                    state_nxt_s = ST_IDLE;
                    done_s      = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latched downstream request; requester inputs are ignored until completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {LINE_BITS{1'b0}};
            grant_r     <= GRANT_NONE;
        end else if (load_s) begin
            mem_read_r  <= (op_s == OP_READ);
            mem_write_r <= (op_s == OP_WRITE);
            mem_addr_r  <= aligned_addr_s;
            mem_wdata_r <= (sel_grant_s == GRANT_D) ? d_wdata : {LINE_BITS{1'b0}};
            grant_r     <= sel_grant_s;
        end else if (done_s) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
            grant_r     <= GRANT_NONE;
        end else begin
            mem_read_r  <= mem_read_r;
            mem_write_r <= mem_write_r;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
            grant_r     <= grant_r;
        end
    end

    // Ready must pulse in the same cycle as mem_ready, so it is decoded from state.
    assign i_ready   = (state_r == ST_SERVE_I) & mem_ready;
    assign d_ready   = (state_r == ST_SERVE_D) & mem_ready;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign grant     = grant_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (honours MEM_ARB_ROUND_ROBIN_EN for tie expectations).
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_ready;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_ready;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic [1:0]   grant;

    int checks = 0;
    int errors = 0;

    logic [1:0]   exp_grant [3];
    logic [127:0] line_a5;
    logic [127:0] line_wb;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        line_a5 = {16{8'hA5}};
        line_wb = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_grant[0] = 2'b10; exp_grant[1] = 2'b01; exp_grant[2] = 2'b10;
`else
        exp_grant[0] = 2'b10; exp_grant[1] = 2'b10; exp_grant[2] = 2'b10;
`endif
        rst = 1'b1; i_read = 1'b0; i_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
        d_addr = 32'h0; d_wdata = 128'h0; mem_rdata = 128'h0; mem_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_ready", {i_ready, d_ready}, 2'b00);
        nc(); nc();
        rst = 1'b1;

        // icache fill with a misaligned address
        nc(); i_read = 1'b1; i_addr = 32'h0000_1234; #1;
        chk("i_lat_cycleN", mem_read, 1'b0);
        nc();
        chk("i_mem_read_N1", mem_read, 1'b1);
        chk("i_mem_addr", mem_addr, 32'h0000_1230);
        chk("i_grant", grant, 2'b01);
        chk("i_ready_early", i_ready, 1'b0);
        nc(); i_addr = 32'hFFFF_FFFF; #1;
        chk("i_mem_read_N2", mem_read, 1'b1);
        chk("i_addr_ignored", mem_addr, 32'h0000_1230);
        nc(); mem_ready = 1'b1; mem_rdata = line_a5; #1;
        chk("i_mem_read_N3", mem_read, 1'b1);
        chk("i_ready_pulse", i_ready, 1'b1);
        chk("i_d_ready_low", d_ready, 1'b0);
        chk("i_rdata", i_rdata, line_a5);
        chk("d_rdata_mirror", d_rdata, line_a5);
        nc(); mem_ready = 1'b0; i_read = 1'b0; #1;
        chk("i_done_mem_read", mem_read, 1'b0);
        chk("i_done_grant", grant, 2'b00);
        chk("i_done_ready", i_ready, 1'b0);

        // dcache write-back
        d_write = 1'b1; d_addr = 32'h8000_0040; d_wdata = line_wb;
        nc();
        chk("d_wr_mem_write", mem_write, 1'b1);
        chk("d_wr_mem_read", mem_read, 1'b0);
        chk("d_wr_wdata", mem_wdata, line_wb);
        chk("d_wr_addr", mem_addr, 32'h8000_0040);
        chk("d_wr_grant", grant, 2'b10);
        mem_ready = 1'b1; #1;
        chk("d_wr_ready", {d_ready, i_ready}, 2'b10);
        nc(); mem_ready = 1'b0; d_write = 1'b0; #1;
        chk("d_wr_done", {mem_write, grant}, 3'b000);

        // spurious mem_ready while idle
        mem_ready = 1'b1; #1;
        chk("spur_ready", {i_ready, d_ready}, 2'b00);
        nc(); mem_ready = 1'b0; #1;
        chk("spur_idle", {mem_read, mem_write, grant}, 4'b0000);

        // write-back and fill together: write first, then read; read requester drops mid-serve
        d_write = 1'b1; d_read = 1'b1; d_addr = 32'h0000_2000;
        nc();
        chk("wr_first", {mem_write, mem_read}, 2'b10);
        mem_ready = 1'b1; #1;
        chk("wr_first_ready", d_ready, 1'b1);
        nc(); mem_ready = 1'b0; d_write = 1'b0; #1;
        chk("wr_then_idle", {mem_write, mem_read, grant}, 4'b0000);
        nc();
        chk("rd_second", {mem_write, mem_read, grant}, 4'b0110);
        d_read = 1'b0;
        nc(); mem_ready = 1'b1; #1;
        chk("rd_drop_ready", d_ready, 1'b1);
        nc(); mem_ready = 1'b0; #1;

        // fresh reset so the tie pointer starts at icache-last
        rst = 1'b0; nc(); rst = 1'b1;

        for (int k = 0; k < 3; k++) begin
            nc(); i_read = 1'b1; d_read = 1'b1; i_addr = 32'h100; d_addr = 32'h200;
            nc();
            chk("tie_grant", grant, exp_grant[k]);
            mem_ready = 1'b1; #1;
            chk("tie_ready", {d_ready, i_ready}, exp_grant[k]);
            nc(); mem_ready = 1'b0; i_read = 1'b0; d_read = 1'b0;
        end

        // reset while dcache waits on memory
        nc(); d_read = 1'b1; d_addr = 32'h0000_0100;
        nc();
        chk("abort_pre_grant", {grant, mem_read}, 3'b101);
        nc(); rst = 1'b0; mem_ready = 1'b1; #1;
        chk("abort_outputs", {grant, mem_read, mem_write, d_ready, i_ready}, 6'b000000);
        chk("abort_addr", mem_addr, 32'h0);
        d_read = 1'b0; mem_ready = 1'b0;
        nc(); rst = 1'b1;
        nc(); i_read = 1'b1; i_addr = 32'h0000_0044;
        nc();
        chk("post_rst_grant", grant, 2'b01);
        chk("post_rst_addr", mem_addr, 32'h0000_0040);
        mem_ready = 1'b1; #1;
        chk("post_rst_ready", {i_ready, d_ready}, 2'b10);
        nc(); mem_ready = 1'b0; i_read = 1'b0;
        nc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter LINE_BITS, default 128, cache-line width (4 words).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_read  input  1  instruction-cache line-fill request, level, held until i_ready.
REQ-006 i_addr  input  ADDR_WIDTH  instruction-cache line address.
REQ-007 i_rdata  output  LINE_BITS  fill data to instruction cache.
REQ-008 i_ready  output  1  one-cycle completion pulse to instruction cache.
REQ-009 d_read  input  1  data-cache fill request, level, held until d_ready.
REQ-010 d_write  input  1  data-cache write-back request, level, held until d_ready.
REQ-011 d_addr  input  ADDR_WIDTH  data-cache line address.
REQ-012 d_wdata  input  LINE_BITS  write-back line.
REQ-013 d_rdata  output  LINE_BITS  fill data to data cache.
REQ-014 d_ready  output  1  one-cycle completion pulse to data cache.
REQ-015 mem_read / mem_write  output  1 each  downstream request, held until mem_ready.
REQ-016 mem_addr  output  ADDR_WIDTH  downstream line address; mem_wdata  output  LINE_BITS.
REQ-017 mem_rdata  input  LINE_BITS; mem_ready  input  1  downstream completion pulse.
REQ-018 grant  output  2  one-hot owner: 2'b01 icache, 2'b10 dcache, 2'b00 idle.

Function
REQ-019 FSM states IDLE, SERVE_I, SERVE_D; one transaction in flight maximum.
REQ-020 IDLE: evaluate requests each cycle; chosen requester's addr/wdata/op latched, next state SERVE_x; no request stays IDLE.
REQ-021 Grant latency: request visible in cycle N -> mem_read/mem_write asserted from cycle N+1 (registered).
REQ-022 SERVE_x: downstream outputs driven only from latched copies; requester input changes ignored until completion.
REQ-023 mem_addr low log2(LINE_BITS/8) bits forced to zero (line-aligned).
REQ-024 d_write and d_read both high: write-back served first, read served as a separate later transaction.
REQ-025 mem_ready in SERVE_x: x_ready pulses same cycle, downstream request deasserted next cycle, next state IDLE.
REQ-026 mem_ready in IDLE: ignored, no ready pulse to either requester.
REQ-027 i_rdata and d_rdata both combinationally equal mem_rdata; only granted port's ready pulses.
REQ-028 Requester dropping its request mid-SERVE: transaction still completes; ready pulse still issued.
REQ-029 Requests re-asserted in the cycle after ready: evaluated normally in IDLE (min one idle cycle between transactions).

Reset
REQ-030 rst low: state IDLE, grant 0, mem_read/mem_write 0, mem_addr/mem_wdata 0, i_ready/d_ready 0, round-robin pointer to icache-last.
REQ-031 rst low mid-transaction: transaction aborted immediately, no ready pulse; downstream responsible for discarding.

Configuration
REQ-032 Macro MEM_ARB_ROUND_ROBIN_EN defined: simultaneous i/d requests granted to port not served last; pointer updated on each completion.
REQ-033 Macro undefined: fixed priority, dcache always wins simultaneous requests; no pointer state.

Structure
REQ-034 Package mem_arb_pkg: state enum, grant one-hot typedef, LINE_BITS/ADDR_WIDTH defaults, op typedef (READ/WRITE).
REQ-035 One sub-module arb_grant_sel: combinational picker (requests, last-served) -> one-hot grant.

Verification
REQ-036 i_read=1, i_addr=0x0000_1234; mem_ready 3 cycles later with rdata=0xA5..A5 -> mem_addr=0x0000_1230, mem_read high cycles N+1..N+3, i_ready one pulse, i_rdata=0xA5..A5, d_ready 0.
REQ-037 d_write=1, d_addr=0x8000_0040, d_wdata=0x1111_2222_3333_4444_... -> mem_write=1, mem_wdata matches, d_ready pulse on mem_ready, then IDLE.
REQ-038 i_read and d_read both asserted, macro undefined, repeated 3 times -> dcache granted every time.
REQ-039 Same stimulus with MEM_ARB_ROUND_ROBIN_EN -> grants alternate 2'b10, 2'b01, 2'b10.
REQ-040 rst pulled low while SERVE_D waiting on mem_ready -> all outputs 0 same cycle, no d_ready; after release, i_read served normally.
REQ-041 Spurious mem_ready=1 in IDLE -> i_ready=d_ready=0, state stays IDLE.
